spi_ioc_slave: RTL and testbench

- SPI slave front end that decodes host frames into the per-module IOC command bus (ioc, data, cs, fetch/load strobes) consumed by sys_ctrl and its sibling control modules.
- Oversamples SCK/MOSI/CS_b on the system clock.
- Decodes a 2-byte frame: command byte, then data byte.
- Returns read data on MISO from the selected module's read-data bus.

---
 rtl/spi_ioc_pkg.sv | 30 +++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_ioc_slave.sv | 204 ++++++++++++++++++++
 tb/tb_spi_ioc_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_ioc_pkg.sv
// Shared definitions for the SPI-to-IOC front end: command byte layout,
// module-select codes and the frame state machine encoding.
package spi_ioc_pkg;

    localparam logic [1:0] MOD_SYS_CTRL = 2'd0;
    localparam logic [1:0] MOD_IO_CTRL  = 2'd1;
    localparam logic [1:0] MOD_SMI_CTRL = 2'd2;

    localparam int MAX_MODULES = 4;

    localparam int CMD_DIR_BIT = 7;
    localparam int CMD_SEL_HI  = 6;
    localparam int CMD_SEL_LO  = 5;
    localparam int CMD_IOC_HI  = 4;
    localparam int CMD_IOC_LO  = 0;

    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } spi_state_e;

    function automatic logic [1:0] cmd_sel(input logic [7:0] cmd);
        return cmd[CMD_SEL_HI:CMD_SEL_LO];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_sys_clk,
    input  logic i_rst_b,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
            prev_reg <= RESET_VAL;
        end else begin
            meta_reg <= i_pin;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign o_level = sync_reg;
    assign o_rise  = sync_reg & ~prev_reg;
    assign o_fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/spi_ioc_slave.sv
// SPI mode-0 slave that turns a command byte plus a data byte into IOC bus
// strobes, and shifts the selected module's read data back out on MISO.
module spi_ioc_slave
    import spi_ioc_pkg::*;
#(
    parameter int NUM_MODULES = 4
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst_b,
    input  logic                     i_spi_sck,
    input  logic                     i_spi_mosi,
    input  logic                     i_spi_cs_b,
    output logic                     o_spi_miso,
    output logic [4:0]               o_ioc,
    output logic [7:0]               o_data_out,
    input  logic [8*NUM_MODULES-1:0] i_data_in,
    output logic [NUM_MODULES-1:0]   o_cs,
    output logic                     o_fetch_cmd,
    output logic                     o_load_cmd
);

    logic sck_lvl_unused, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
    logic cs_lvl, cs_rise, cs_fall;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
        .i_sys_clk (i_sys_clk), .i_rst_b (i_rst_b), .i_pin (i_spi_sck),
        .o_level (sck_lvl_unused), .o_rise (sck_rise), .o_fall (sck_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .i_sys_clk (i_sys_clk), .i_rst_b (i_rst_b), .i_pin (i_spi_mosi),
        .o_level (mosi_lvl), .o_rise (mosi_rise_unused), .o_fall (mosi_fall_unused)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .i_sys_clk (i_sys_clk), .i_rst_b (i_rst_b), .i_pin (i_spi_cs_b),
        .o_level (cs_lvl), .o_rise (cs_rise), .o_fall (cs_fall)
    );

    spi_state_e             state_reg, state_next;
    logic [2:0]             bit_cnt_reg, bit_cnt_next;
    logic [6:0]             shift_reg, shift_next;
    logic [1:0]             sel_reg, sel_next;
    logic                   dir_reg, dir_next;
    logic [4:0]             ioc_reg, ioc_next;
    logic [7:0]             data_out_reg, data_out_next;
    logic [NUM_MODULES-1:0] cs_reg, cs_next;
    logic                   fetch_reg, fetch_next;
    logic                   fetch_pend_reg, fetch_pend_next;
    logic                   load_reg, load_next;
    logic                   load_pend_reg, load_pend_next;
    logic [7:0]             miso_sr_reg, miso_sr_next;
    logic                   miso_reg, miso_next;
    logic [1:0]             settle_reg, settle_next;
    logic                   armed_reg, armed_next;

    logic [7:0]             shifted_byte;
    logic [1:0]             new_sel;
    logic [NUM_MODULES-1:0] cs_decode;
    logic [7:0]             rd_bytes [MAX_MODULES];
    logic                   frame_start, cmd_done, data_done;

    assign shifted_byte = {shift_reg, mosi_lvl};
    assign new_sel      = cmd_sel(shifted_byte);

    // Unmapped select codes read back as zero and decode to no chip select.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_MODULES; gi++) begin : g_mod
            if (gi < NUM_MODULES) begin : g_map
                assign rd_bytes[gi]  = i_data_in[gi*8 +: 8];
                assign cs_decode[gi] = (new_sel == 2'(gi));
            end else begin : g_unmap
                assign rd_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    // A CS fall is only honoured once CS_b has been seen high after reset,
    // so a frame interrupted by reset is ignored until the host re-frames.
    assign frame_start = (state_reg == ST_IDLE) && cs_fall && armed_reg;
    assign cmd_done    = (state_reg == ST_CMD) && sck_rise && !cs_rise && (bit_cnt_reg == 3'd7);
    assign data_done   = (state_reg == ST_DATA) && sck_rise && !cs_rise && (bit_cnt_reg == 3'd7);

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (cs_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (frame_start) state_next = ST_CMD;
                ST_CMD:  if (cmd_done)    state_next = ST_DATA;
                ST_DATA: if (data_done)   state_next = ST_DONE;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        sel_next        = sel_reg;
        dir_next        = dir_reg;
        ioc_next        = ioc_reg;
        data_out_next   = data_out_reg;
        cs_next         = cs_reg;
        fetch_next      = 1'b0;
        fetch_pend_next = fetch_reg;
        load_next       = load_pend_reg;
        load_pend_next  = 1'b0;
        miso_sr_next    = miso_sr_reg;
        miso_next       = miso_reg;
        settle_next     = (settle_reg == 2'd2) ? settle_reg : settle_reg + 2'd1;
        armed_next      = armed_reg | ((settle_reg == 2'd2) && cs_lvl);

        if (frame_start) begin
            bit_cnt_next = 3'd0;
        end

        if ((state_reg == ST_CMD || state_reg == ST_DATA) && sck_rise && !cs_rise) begin
            shift_next   = shifted_byte[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
        end

        if (cmd_done) begin
            ioc_next   = shifted_byte[CMD_IOC_HI:CMD_IOC_LO];
            sel_next   = new_sel;
            dir_next   = shifted_byte[CMD_DIR_BIT];
            cs_next    = cs_decode;
            fetch_next = (shifted_byte[CMD_DIR_BIT] != DIR_WRITE);
        end

        if ((state_reg == ST_DATA) && (dir_reg != DIR_WRITE) && sck_fall && !cs_rise) begin
            miso_next    = miso_sr_reg[7];
            miso_sr_next = {miso_sr_reg[6:0], 1'b0};
        end

        // Read data is captured two cycles after fetch, giving the module time to respond.
        if (fetch_pend_reg) begin
            miso_sr_next = rd_bytes[sel_reg];
        end

        if (data_done && (dir_reg == DIR_WRITE)) begin
            data_out_next  = shifted_byte;
            load_pend_next = |cs_reg;
        end

        if (cs_rise) begin
            cs_next   = '0;
            miso_next = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            sel_reg        <= '0;
            dir_reg        <= 1'b0;
            ioc_reg        <= '0;
            data_out_reg   <= '0;
            cs_reg         <= '0;
            fetch_reg      <= 1'b0;
            fetch_pend_reg <= 1'b0;
            load_reg       <= 1'b0;
            load_pend_reg  <= 1'b0;
            miso_sr_reg    <= '0;
            miso_reg       <= 1'b0;
            settle_reg     <= '0;
            armed_reg      <= 1'b0;
        end else begin
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            sel_reg        <= sel_next;
            dir_reg        <= dir_next;
            ioc_reg        <= ioc_next;
            data_out_reg   <= data_out_next;
            cs_reg         <= cs_next;
            fetch_reg      <= fetch_next;
            fetch_pend_reg <= fetch_pend_next;
            load_reg       <= load_next;
            load_pend_reg  <= load_pend_next;
            miso_sr_reg    <= miso_sr_next;
            miso_reg       <= miso_next;
            settle_reg     <= settle_next;
            armed_reg      <= armed_next;
        end
    end

    assign o_spi_miso  = miso_reg;
    assign o_ioc       = ioc_reg;
    assign o_data_out  = data_out_reg;
    assign o_cs        = cs_reg;
    assign o_fetch_cmd = fetch_reg;
    assign o_load_cmd  = load_reg;

endmodule

// File: tb/tb_spi_ioc_slave.sv
// Scoreboard bench: host-side SPI driver pushes expected strobes and MISO
// bytes; an independent monitor pops and compares as the DUT produces them.
module tb_spi_ioc_slave;
    import spi_ioc_pkg::*;

    localparam int NM = 3;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          spi_sck, spi_mosi, spi_cs_b;
    logic          o_spi_miso;
    logic [4:0]    o_ioc;
    logic [7:0]    o_data_out;
    logic [8*NM-1:0] data_in;
    logic [NM-1:0] o_cs;
    logic          o_fetch_cmd, o_load_cmd;

    spi_ioc_slave #(.NUM_MODULES(NM)) dut (
        .i_sys_clk   (clk),
        .i_rst_b     (rst_b),
        .i_spi_sck   (spi_sck),
        .i_spi_mosi  (spi_mosi),
        .i_spi_cs_b  (spi_cs_b),
        .o_spi_miso  (o_spi_miso),
        .o_ioc       (o_ioc),
        .o_data_out  (o_data_out),
        .i_data_in   (data_in),
        .o_cs        (o_cs),
        .o_fetch_cmd (o_fetch_cmd),
        .o_load_cmd  (o_load_cmd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_load;
        logic [4:0] ioc;
        logic [7:0] data;
        logic [2:0] cs;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] exp_miso_q[$];
    logic [7:0] got_miso_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input bit is_load, input logic [4:0] ioc, input logic [7:0] data,
                           input logic [2:0] cs);
        ev_t e;
        e.is_load = is_load;
        e.ioc     = ioc;
        e.data    = data;
        e.cs      = cs;
        exp_q.push_back(e);
    endtask

    // Monitor: compares strobes and captured MISO bytes against the queues.
    always @(negedge clk) begin
        ev_t e;
        logic [7:0] g, x;
        if (o_fetch_cmd && o_load_cmd) begin
            chk("strobe_exclusive", 32'd1, 32'd0);
        end else if (o_fetch_cmd || o_load_cmd) begin
            $display("txn %s ioc=%0d data=%02h cs=%b t=%0t",
                     o_load_cmd ? "load " : "fetch", o_ioc, o_data_out, o_cs, $time);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, o_load_cmd, o_fetch_cmd}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", {31'd0, o_load_cmd}, {31'd0, e.is_load});
                chk("strobe_ioc", {27'd0, o_ioc}, {27'd0, e.ioc});
                chk("strobe_cs", {29'd0, o_cs}, {29'd0, e.cs});
                if (e.is_load) chk("load_data", {24'd0, o_data_out}, {24'd0, e.data});
            end
        end
        while (got_miso_q.size() > 0) begin
            g = got_miso_q.pop_front();
            x = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 8'hxx;
            $display("txn miso byte=%02h t=%0t", g, $time);
            chk("miso_byte", {24'd0, g}, {24'd0, x});
        end
    end

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            #60;
            spi_sck = 1'b1;
            rx[i]   = o_spi_miso;
            #60;
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input int ndata,
                         input logic [2:0] cs_exp, input bit cap, input int gap);
        logic [7:0] r0, r1;
        spi_cs_b = 1'b0;
        #60;
        spi_bits(cmd, 8, r0);
        #20;
        chk("cs_decode", {29'd0, o_cs}, {29'd0, cs_exp});
        chk("ioc_latch", {27'd0, o_ioc}, {27'd0, cmd[4:0]});
        spi_bits(dat, ndata, r1);
        #60;
        spi_cs_b = 1'b1;
        if (cap) begin
            got_miso_q.push_back(r0);
            got_miso_q.push_back(r1);
        end
        #30;
        chk("cs_clear", {29'd0, o_cs}, 32'd0);
        chk("miso_idle", {31'd0, o_spi_miso}, 32'd0);
        chk("ioc_hold", {27'd0, o_ioc}, {27'd0, cmd[4:0]});
        #(gap - 30);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ioc"}, {27'd0, o_ioc}, 32'd0);
        chk({tag, "_data"}, {24'd0, o_data_out}, 32'd0);
        chk({tag, "_cs"}, {29'd0, o_cs}, 32'd0);
        chk({tag, "_fetch"}, {31'd0, o_fetch_cmd}, 32'd0);
        chk({tag, "_load"}, {31'd0, o_load_cmd}, 32'd0);
        chk({tag, "_miso"}, {31'd0, o_spi_miso}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        rst_b    = 1'b0;
        spi_cs_b = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        data_in  = {8'hC3, 8'h5A, 8'hA5};
        #1;
        chk_all_zero("reset");
        #29;
        rst_b = 1'b1;
        #100;

        // Write sys_ctrl soft reset
        push_ev(1'b1, 5'd4, 8'h01, 3'b001);
        frame(8'h84, 8'h01, 8, 3'b001, 1'b0, 100);
        chk("data_out_w1", {24'd0, o_data_out}, 32'h01);

        // Read sys_ctrl
        push_ev(1'b0, 5'd3, 8'h00, 3'b001);
        exp_miso_q.push_back(8'h00);
        exp_miso_q.push_back(8'hA5);
        frame(8'h03, 8'h00, 8, 3'b001, 1'b1, 100);

        // Unmapped module 3: write gives nothing, read returns zero
        frame(8'hE1, 8'h55, 8, 3'b000, 1'b0, 100);
        push_ev(1'b0, 5'd1, 8'h00, 3'b000);
        exp_miso_q.push_back(8'h00);
        exp_miso_q.push_back(8'h00);
        frame(8'h61, 8'h00, 8, 3'b000, 1'b1, 100);

        // Abort after 5 data bits, then a complete frame
        frame(8'hA2, 8'h3C, 5, 3'b010, 1'b0, 100);
        push_ev(1'b1, 5'd2, 8'h3C, 3'b010);
        frame(8'hA2, 8'h3C, 8, 3'b010, 1'b0, 100);
        chk("data_out_w2", {24'd0, o_data_out}, 32'h3C);

        // Reset in the middle of the command byte
        spi_cs_b = 1'b0;
        #60;
        spi_bits(8'h84, 4, r);
        #20;
        rst_b = 1'b0;
        #1;
        chk_all_zero("midreset");
        #29;
        rst_b = 1'b1;
        spi_bits(8'h0F, 4, r);
        spi_bits(8'h55, 8, r);
        chk("post_reset_cs", {29'd0, o_cs}, 32'd0);
        #60;
        spi_cs_b = 1'b1;
        #100;
        push_ev(1'b1, 5'd4, 8'h01, 3'b001);
        frame(8'h84, 8'h01, 8, 3'b001, 1'b0, 100);
        chk("data_out_w3", {24'd0, o_data_out}, 32'h01);

        // Back-to-back write then read with a 4-clock CS_b gap
        push_ev(1'b1, 5'd5, 8'h7E, 3'b001);
        frame(8'h85, 8'h7E, 8, 3'b001, 1'b0, 40);
        push_ev(1'b0, 5'd3, 8'h00, 3'b010);
        exp_miso_q.push_back(8'h00);
        exp_miso_q.push_back(8'h5A);
        frame(8'h23, 8'h00, 8, 3'b010, 1'b1, 100);

        #200;
        chk("strobes_outstanding", exp_q.size(), 32'd0);
        chk("miso_outstanding", exp_miso_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
